// File: rtl/bus_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl_if
//  Description : Request handshake and datapath-bus bundle for bus_xfer_ctrl.
//                The "slave" modport is taken by the transfer controller.
//                The "master" modport is taken by the requester/latch side.
//
//                Requester -> controller : req_valid, req_src, req_dst,
//                                          req_inc, req_mask
//                Latch file -> controller: x_bus
//                Controller -> requester : req_ready, done, err, xfer_cnt,
//                                          xfer_data
//                Controller -> latches   : out_en, in_en, in_mask, alu_inc
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_xfer_ctrl_if #(
    parameter int NREGS = 8,
    parameter int WIDTH = 8
) ();
    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_src;
    logic [IDX_W-1:0] req_dst;
    logic             req_inc;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] x_bus;
    logic [NREGS-1:0] out_en;
    logic [NREGS-1:0] in_en;
    logic [WIDTH-1:0] in_mask;
    logic             alu_inc;
    logic [WIDTH-1:0] xfer_data;
    logic             done;
    logic             err;
    logic [15:0]      xfer_cnt;

    modport slave (
        input  req_valid, req_src, req_dst, req_inc, req_mask, x_bus,
        output req_ready, out_en, in_en, in_mask, alu_inc, xfer_data,
               done, err, xfer_cnt
    );

    modport master (
        output req_valid, req_src, req_dst, req_inc, req_mask, x_bus,
        input  req_ready, out_en, in_en, in_mask, alu_inc, xfer_data,
               done, err, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_xfer_ctrl
//  Description : Bus transfer initiator. For each accepted request it enables
//                the source latch onto x_bus (DRIVE), keeps it enabled while
//                strobing the destination latch input enable (LOAD), then
//                reports completion (DONE). All outputs are registered.
//
//  Ports       : ph1    - clock, all state changes on rising edge
//                reset  - synchronous active-high reset
//                bus    - bus_xfer_ctrl_if.slave (request handshake, x_bus
//                         snoop, latch enables, status and counters)
//  Revision    : 1.0  initial release
// ============================================================================
module bus_xfer_ctrl #(
    parameter int NREGS    = 8,
    parameter int WIDTH    = 8,
    parameter int FLAG_IDX = 7
) (
    input  wire logic         ph1,
    input  wire logic         reset,
    bus_xfer_ctrl_if.slave    bus
);

    localparam int                 IDX_W      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [NREGS-1:0]   c_ONE      = NREGS'(1);
    localparam logic [IDX_W-1:0]   c_MAX_IDX  = IDX_W'(NREGS - 1);
    localparam logic [IDX_W-1:0]   c_FLAG_IDX = IDX_W'(FLAG_IDX);
    localparam logic [15:0]        c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_src;
    logic [IDX_W-1:0] r_dst;
    logic             r_inc;
    logic [WIDTH-1:0] r_mask;
    logic [NREGS-1:0] r_out_en;
    logic [NREGS-1:0] r_in_en;
    logic [WIDTH-1:0] r_in_mask;
    logic             r_alu_inc;
    logic [WIDTH-1:0] r_xfer_data;
    logic             r_done;
    logic             r_err;
    logic             r_ready;
    logic [15:0]      r_xfer_cnt;

    state_t           w_next_state;
    logic             w_accept;
    logic             w_src_ok;
    logic             w_dst_ok;
    logic             w_req_ok;
    logic             w_latch;
    logic [NREGS-1:0] w_out_en_nx;
    logic [NREGS-1:0] w_in_en_nx;
    logic [WIDTH-1:0] w_in_mask_nx;
    logic             w_alu_inc_nx;
    logic             w_done_nx;
    logic             w_err_nx;
    logic             w_ready_nx;

    // r_ready is only ever set while the FSM sits in IDLE or DONE, so it
    // doubles as the "can accept" qualifier.
    assign w_accept = bus.req_valid & r_ready;

    // Out-of-range indices only exist when NREGS is not a power of two.
    generate
        if (NREGS == (1 << IDX_W)) begin : g_pow2_range
            assign w_src_ok = 1'b1;
            assign w_dst_ok = 1'b1;
        end else begin : g_partial_range
            assign w_src_ok = (bus.req_src <= c_MAX_IDX);
            assign w_dst_ok = (bus.req_dst <= c_MAX_IDX);
        end
    endgenerate

    assign w_req_ok = w_src_ok & w_dst_ok;

    // ------------------------------------------------------------------
    // Next-state and next-output decode. Outputs are computed one cycle
    // ahead and registered so the enables are glitch-free for a full cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_out_en_nx  = '0;
        w_in_en_nx   = '0;
        w_in_mask_nx = '0;
        w_alu_inc_nx = 1'b0;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;
        w_ready_nx   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_next_state = S_IDLE;
                w_ready_nx   = 1'b1;
                if (w_accept) begin
                    if (w_req_ok) begin
                        w_latch      = 1'b1;
                        w_next_state = S_DRIVE;
                        w_out_en_nx  = c_ONE << bus.req_src;
                        w_alu_inc_nx = bus.req_inc;
                        w_ready_nx   = 1'b0;
                    end else begin
                        // Consumed but dropped: report and remain idle.
                        w_err_nx = 1'b1;
                    end
                end
            end

            S_DRIVE: begin
                // Source stays on x_bus through LOAD so the ALU output is
                // stable while the destination samples it.
                w_next_state = S_LOAD;
                w_out_en_nx  = c_ONE << r_src;
                w_in_en_nx   = c_ONE << r_dst;
                w_in_mask_nx = (r_dst == c_FLAG_IDX) ? r_mask : {WIDTH{1'b1}};
                w_alu_inc_nx = r_inc;
            end

            S_LOAD: begin
                w_next_state = S_DONE;
                w_done_nx    = 1'b1;
                w_ready_nx   = 1'b1;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request fields and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_inc       <= 1'b0;
            r_mask      <= '0;
            r_out_en    <= '0;
            r_in_en     <= '0;
            r_in_mask   <= '0;
            r_alu_inc   <= 1'b0;
            r_xfer_data <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_out_en  <= w_out_en_nx;
            r_in_en   <= w_in_en_nx;
            r_in_mask <= w_in_mask_nx;
            r_alu_inc <= w_alu_inc_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
            r_ready   <= w_ready_nx;

            if (w_latch) begin
                r_src  <= bus.req_src;
                r_dst  <= bus.req_dst;
                r_inc  <= bus.req_inc;
                r_mask <= bus.req_mask;
            end

            // The LOAD-ending edge is the commit point: capture the source
            // value and count the transfer alongside the done pulse.
            if (r_state == S_LOAD) begin
                r_xfer_data <= bus.x_bus;
                if (r_xfer_cnt != c_CNT_MAX) begin
                    r_xfer_cnt <= r_xfer_cnt + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.out_en    = r_out_en;
    assign bus.in_en     = r_in_en;
    assign bus.in_mask   = r_in_mask;
    assign bus.alu_inc   = r_alu_inc;
    assign bus.xfer_data = r_xfer_data;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_xfer_ctrl
//  Description : Self-checking bench for bus_xfer_ctrl. An 8-register
//                instance is exercised with a scoreboard of expected
//                transfers; a 6-register instance covers rejected indices.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_xfer_ctrl;

    localparam int FLAG_IDX = 7;

    logic ph1   = 1'b0;
    logic reset = 1'b1;
    always #5 ph1 = ~ph1;

    bus_xfer_ctrl_if #(.NREGS(8), .WIDTH(8)) m  ();
    bus_xfer_ctrl_if #(.NREGS(6), .WIDTH(8)) m6 ();

    bus_xfer_ctrl #(.NREGS(8), .WIDTH(8), .FLAG_IDX(FLAG_IDX)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (m)
    );

    bus_xfer_ctrl #(.NREGS(6), .WIDTH(8), .FLAG_IDX(FLAG_IDX)) dut6 (
        .ph1   (ph1),
        .reset (reset),
        .bus   (m6)
    );

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        logic       inc;
        logic [7:0] mask;
        logic [7:0] data;
        int         done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] exp_cnt;
    logic [7:0]  regs [8];
    logic [7:0]  w_xbus;

    always @(posedge ph1) cyc <= cyc + 1;

    // Latch-file model: whichever latch is output-enabled drives x_bus.
    always_comb begin
        w_xbus = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m.out_en[i]) w_xbus = regs[i];
        end
    end
    assign m.x_bus  = w_xbus;
    assign m6.x_bus = 8'h00;

    // Continuous scoreboard monitor for the 8-register instance.
    task automatic monitor();
        logic [7:0] oh_s;
        logic [7:0] oh_d;
        logic [7:0] msk;
        forever begin
            @(negedge ph1);
            if (reset) begin
                sb.delete();
                exp_cnt = 16'h0000;
            end else begin
                checks++;
                if (!$onehot0(m.out_en) || !$onehot0(m.in_en) ||
                    (m.in_en != 8'h00 && m.out_en == 8'h00)) begin
                    errors++;
                    $display("FAIL enable_invariant: out_en=%h in_en=%h (need one-hot0, in_en only with out_en)",
                             m.out_en, m.in_en);
                end
                checks++;
                if (m.in_en == 8'h00 && m.in_mask !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_mask: in_mask=%h required 00 while in_en=0", m.in_mask);
                end
                checks++;
                if (m.err !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_err: err=%b required 0", m.err);
                end
                if (m.out_en != 8'h00) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL enable_without_request: out_en=%h required 00", m.out_en);
                    end else begin
                        oh_s = 8'h01 << sb[0].src;
                        oh_d = 8'h01 << sb[0].dst;
                        msk  = (sb[0].dst == 3'(FLAG_IDX)) ? sb[0].mask : 8'hFF;
                        if (m.out_en !== oh_s || m.alu_inc !== sb[0].inc) begin
                            errors++;
                            $display("FAIL sb_source: out_en=%h alu_inc=%b required %h/%b",
                                     m.out_en, m.alu_inc, oh_s, sb[0].inc);
                        end
                        if (m.in_en != 8'h00) begin
                            checks++;
                            if (m.in_en !== oh_d || m.in_mask !== msk) begin
                                errors++;
                                $display("FAIL sb_load: in_en=%h in_mask=%h required %h/%h",
                                         m.in_en, m.in_mask, oh_d, msk);
                            end
                        end
                    end
                end
                if (m.done === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no transfer pending");
                    end else begin
                        exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
                        if (m.xfer_data !== sb[0].data || m.xfer_cnt !== exp_cnt ||
                            cyc != sb[0].done_cyc || m.out_en !== 8'h00) begin
                            errors++;
                            $display("FAIL sb_done: data=%h cnt=%0d cyc=%0d out_en=%h required %h/%0d/%0d/00",
                                     m.xfer_data, m.xfer_cnt, cyc, m.out_en,
                                     sb[0].data, exp_cnt, sb[0].done_cyc);
                        end
                        void'(sb.pop_front());
                    end
                end
            end
        end
    endtask

    // Present a request at a negedge and wait for it to be taken; returns at
    // the negedge following the accepting edge with req_valid still high.
    task automatic send(input logic [2:0] s, input logic [2:0] d,
                        input logic i, input logic [7:0] mk);
        exp_t e;
        m.req_src   = s;
        m.req_dst   = d;
        m.req_inc   = i;
        m.req_mask  = mk;
        m.req_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (m.req_ready === 1'b1) begin
                e.src      = s;
                e.dst      = d;
                e.inc      = i;
                e.mask     = mk;
                e.data     = regs[s];
                e.done_cyc = cyc + 3;
                sb.push_back(e);
                @(negedge ph1);
                return;
            end
            @(negedge ph1);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: req_ready=%b required 1 within 20 cycles", m.req_ready);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge ph1);
        checks++;
        if (m.out_en !== 8'h00 || m.in_en !== 8'h00) begin
            errors++;
            $display("FAIL reset_enables: out_en=%h in_en=%h required 00/00", m.out_en, m.in_en);
        end
        checks++;
        if (m.in_mask !== 8'h00 || m.xfer_data !== 8'h00 || m.xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: in_mask=%h xfer_data=%h xfer_cnt=%h required 00/00/0000",
                     m.in_mask, m.xfer_data, m.xfer_cnt);
        end
        checks++;
        if (m.done !== 1'b0 || m.err !== 1'b0 || m.alu_inc !== 1'b0 || m.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: done=%b err=%b alu_inc=%b req_ready=%b required 0/0/0/0",
                     m.done, m.err, m.alu_inc, m.req_ready);
        end
        reset = 1'b0;
        @(negedge ph1);
        checks++;
        if (m.req_ready !== 1'b1 || m6.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: req_ready=%b/%b required 1/1", m.req_ready, m6.req_ready);
        end
    endtask

    task automatic test_reset_in_load();
        send(3'd5, 3'd6, 1'b0, 8'hFF);
        m.req_valid = 1'b0;
        @(negedge ph1);
        checks++;
        if (m.in_en !== 8'h40) begin
            errors++;
            $display("FAIL rst_load_reach: in_en=%h required 40", m.in_en);
        end
        reset = 1'b1;
        @(negedge ph1);
        checks++;
        if (m.out_en !== 8'h00 || m.in_en !== 8'h00 || m.done !== 1'b0 || m.xfer_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL rst_in_load: out_en=%h in_en=%h done=%b cnt=%h required 00/00/0/0000",
                     m.out_en, m.in_en, m.done, m.xfer_cnt);
        end
        @(negedge ph1);
        reset = 1'b0;
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b0 || m.xfer_cnt !== 16'h0000 || m.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_recover: done=%b cnt=%h ready=%b required 0/0000/1",
                     m.done, m.xfer_cnt, m.req_ready);
        end
    endtask

    task automatic test_basic();
        send(3'd0, 3'd1, 1'b0, 8'hFF);
        m.req_valid = 1'b0;
        checks++;
        if (m.out_en !== 8'h01 || m.in_en !== 8'h00 || m.alu_inc !== 1'b0 || m.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_drive: out_en=%h in_en=%h alu_inc=%b ready=%b required 01/00/0/0",
                     m.out_en, m.in_en, m.alu_inc, m.req_ready);
        end
        @(negedge ph1);
        checks++;
        if (m.out_en !== 8'h01 || m.in_en !== 8'h02 || m.in_mask !== 8'hFF) begin
            errors++;
            $display("FAIL basic_load: out_en=%h in_en=%h in_mask=%h required 01/02/FF",
                     m.out_en, m.in_en, m.in_mask);
        end
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b1 || m.xfer_data !== 8'h3C || m.xfer_cnt !== 16'd1 || m.out_en !== 8'h00) begin
            errors++;
            $display("FAIL basic_done: done=%b data=%h cnt=%0d out_en=%h required 1/3C/1/00",
                     m.done, m.xfer_data, m.xfer_cnt, m.out_en);
        end
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b0 || m.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse: done=%b ready=%b required 0/1", m.done, m.req_ready);
        end
    endtask

    task automatic test_rmw();
        send(3'd2, 3'd2, 1'b1, 8'hFF);
        m.req_valid = 1'b0;
        checks++;
        if (m.out_en !== 8'h04 || m.alu_inc !== 1'b1) begin
            errors++;
            $display("FAIL rmw_drive: out_en=%h alu_inc=%b required 04/1", m.out_en, m.alu_inc);
        end
        @(negedge ph1);
        checks++;
        if (m.out_en !== 8'h04 || m.in_en !== 8'h04 || m.alu_inc !== 1'b1) begin
            errors++;
            $display("FAIL rmw_load: out_en=%h in_en=%h alu_inc=%b required 04/04/1",
                     m.out_en, m.in_en, m.alu_inc);
        end
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b1 || m.xfer_data !== 8'hFF || m.alu_inc !== 1'b0 || m.xfer_cnt !== 16'd2) begin
            errors++;
            $display("FAIL rmw_done: done=%b data=%h alu_inc=%b cnt=%0d required 1/FF/0/2",
                     m.done, m.xfer_data, m.alu_inc, m.xfer_cnt);
        end
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b0) begin
            errors++;
            $display("FAIL rmw_single_pulse: done=%b required 0", m.done);
        end
    endtask

    task automatic test_flag_mask();
        send(3'd4, 3'd7, 1'b0, 8'h7E);
        m.req_valid = 1'b0;
        checks++;
        if (m.in_mask !== 8'h00) begin
            errors++;
            $display("FAIL flag_drive_mask: in_mask=%h required 00", m.in_mask);
        end
        @(negedge ph1);
        checks++;
        if (m.in_mask !== 8'h7E || m.in_en !== 8'h80) begin
            errors++;
            $display("FAIL flag_load_mask: in_mask=%h in_en=%h required 7E/80", m.in_mask, m.in_en);
        end
        @(negedge ph1);
        checks++;
        if (m.in_mask !== 8'h00 || m.done !== 1'b1) begin
            errors++;
            $display("FAIL flag_done_mask: in_mask=%h done=%b required 00/1", m.in_mask, m.done);
        end
        @(negedge ph1);
        send(3'd4, 3'd3, 1'b0, 8'h7E);
        m.req_valid = 1'b0;
        @(negedge ph1);
        checks++;
        if (m.in_mask !== 8'hFF || m.in_en !== 8'h08) begin
            errors++;
            $display("FAIL plain_load_mask: in_mask=%h in_en=%h required FF/08", m.in_mask, m.in_en);
        end
        repeat (2) @(negedge ph1);
    endtask

    task automatic test_mask_zero();
        send(3'd1, 3'd7, 1'b1, 8'h00);
        m.req_valid = 1'b0;
        @(negedge ph1);
        checks++;
        if (m.in_en !== 8'h80 || m.in_mask !== 8'h00) begin
            errors++;
            $display("FAIL zero_mask_load: in_en=%h in_mask=%h required 80/00", m.in_en, m.in_mask);
        end
        @(negedge ph1);
        checks++;
        if (m.done !== 1'b1 || m.xfer_cnt !== 16'd5) begin
            errors++;
            $display("FAIL zero_mask_done: done=%b cnt=%0d required 1/5", m.done, m.xfer_cnt);
        end
        @(negedge ph1);
    endtask

    task automatic test_back_to_back();
        int k0;
        int dn[$];
        k0 = cyc;
        fork
            begin
                send(3'd3, 3'd0, 1'b0, 8'hFF);
                send(3'd6, 3'd5, 1'b1, 8'hFF);
                send(3'd0, 3'd7, 1'b0, 8'hC3);
                send(3'd7, 3'd7, 1'b1, 8'h0F);
                m.req_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    @(negedge ph1);
                    if (m.done === 1'b1) dn.push_back(cyc);
                end
            end
        join
        checks++;
        if (dn.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: done pulses=%0d required 4", dn.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (dn[j] != k0 + 3 * (j + 1)) begin
                    errors++;
                    $display("FAIL b2b_timing: done %0d at cycle %0d required %0d", j, dn[j], k0 + 3 * (j + 1));
                end
            end
        end
        checks++;
        if (m.xfer_cnt !== 16'd9 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: cnt=%0d pending=%0d required 9/0", m.xfer_cnt, sb.size());
        end
    endtask

    task automatic test_bad_index();
        m6.req_src   = 3'd7;
        m6.req_dst   = 3'd0;
        m6.req_inc   = 1'b0;
        m6.req_mask  = 8'hFF;
        m6.req_valid = 1'b1;
        @(negedge ph1);
        m6.req_valid = 1'b0;
        checks++;
        if (m6.err !== 1'b1 || m6.out_en !== 6'h00 || m6.in_en !== 6'h00) begin
            errors++;
            $display("FAIL bad_src_err: err=%b out_en=%h in_en=%h required 1/00/00",
                     m6.err, m6.out_en, m6.in_en);
        end
        @(negedge ph1);
        checks++;
        if (m6.err !== 1'b0 || m6.req_ready !== 1'b1 || m6.out_en !== 6'h00 ||
            m6.done !== 1'b0 || m6.xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bad_src_after: err=%b ready=%b out_en=%h done=%b cnt=%0d required 0/1/00/0/0",
                     m6.err, m6.req_ready, m6.out_en, m6.done, m6.xfer_cnt);
        end
        m6.req_src   = 3'd0;
        m6.req_dst   = 3'd6;
        m6.req_valid = 1'b1;
        @(negedge ph1);
        m6.req_valid = 1'b0;
        checks++;
        if (m6.err !== 1'b1 || m6.out_en !== 6'h00) begin
            errors++;
            $display("FAIL bad_dst_err: err=%b out_en=%h required 1/00", m6.err, m6.out_en);
        end
        m6.req_src   = 3'd5;
        m6.req_dst   = 3'd0;
        m6.req_valid = 1'b1;
        @(negedge ph1);
        m6.req_valid = 1'b0;
        checks++;
        if (m6.out_en !== 6'h20 || m6.err !== 1'b0) begin
            errors++;
            $display("FAIL six_drive: out_en=%h err=%b required 20/0", m6.out_en, m6.err);
        end
        repeat (2) @(negedge ph1);
        checks++;
        if (m6.done !== 1'b1 || m6.xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL six_done: done=%b cnt=%0d required 1/1", m6.done, m6.xfer_cnt);
        end
        @(negedge ph1);
    endtask

    initial begin
        regs = '{8'h3C, 8'h11, 8'hFF, 8'h5A, 8'hA5, 8'h96, 8'h69, 8'hE7};
        exp_cnt      = 16'h0000;
        m.req_valid  = 1'b0;
        m.req_src    = 3'd0;
        m.req_dst    = 3'd0;
        m.req_inc    = 1'b0;
        m.req_mask   = 8'h00;
        m6.req_valid = 1'b0;
        m6.req_src   = 3'd0;
        m6.req_dst   = 3'd0;
        m6.req_inc   = 1'b0;
        m6.req_mask  = 8'h00;
        fork
            monitor();
        join_none
        test_reset();
        test_reset_in_load();
        test_basic();
        test_rmw();
        test_flag_mask();
        test_mask_zero();
        test_back_to_back();
        test_bad_index();
        repeat (3) @(negedge ph1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: pending=%0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
